// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: branch funct3 encodings,
// 2-bit pattern-history counter constants and the saturating step function.
package branch_predictor_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  localparam int PHT_CNT_W = 2;
  typedef logic [PHT_CNT_W-1:0] pht_cnt_t;

  // Weakly not-taken start, strongly taken / strongly not-taken limits.
  localparam pht_cnt_t PHT_INIT = 2'b01;
  localparam pht_cnt_t PHT_MAX  = 2'b11;
  localparam pht_cnt_t PHT_MIN  = 2'b00;

  function automatic pht_cnt_t pht_step(input pht_cnt_t cnt, input logic taken);
    pht_cnt_t nxt;
    nxt = cnt;
    if (taken && cnt != PHT_MAX)
      nxt = cnt + pht_cnt_t'(1);
    else if (!taken && cnt != PHT_MIN)
      nxt = cnt - pht_cnt_t'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// One pattern-history-table entry: a 2-bit saturating up/down counter.
module branch_predictor_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     update,
  input  logic     taken,
  output pht_cnt_t count
);

  // NOTE: predictor state is reset (not left as X) so the first fetches
  // after reset predict deterministically; state uses non-blocking updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= PHT_INIT;
    else if (update)
      count <= pht_step(count, taken);
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare/bimodal conditional-branch predictor: combinational fetch-time
// prediction, combinational EX-stage resolution, and registered training.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PHT_ENTRIES = 64,
  parameter int GHR_WIDTH   = 6,
  parameter int CNT_WIDTH   = 32,
  localparam int IDX_W      = $clog2(PHT_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_branch,
  input  logic [XLEN-1:0]      if_pc,
  input  logic [XLEN-1:0]      if_imm,
  output logic                 branch_estimation,
  output logic [XLEN-1:0]      branch_target_predicted,
  input  logic                 branch,
  input  logic                 ex_stall,
  input  logic [2:0]           funct3,
  input  logic                 alu_zero,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_imm,
  input  logic                 ex_estimation,
  input  logic [IDX_W-1:0]     ex_index,
  output logic [IDX_W-1:0]     if_index,
  output logic                 branch_taken,
  output logic [XLEN-1:0]      branch_target_actual,
  output logic                 branch_prediction_miss,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  logic       res_valid;
  logic       taken;
  logic       update_en;
  logic [IDX_W-1:0] ghr_ext;
  pht_cnt_t   pht [PHT_ENTRIES];

  // Resolution decode; funct3 010/011 are not branches and never resolve.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    res_valid = 1'b0;
    taken     = 1'b0;
    if (branch) begin
      case (funct3)
        F3_BEQ, F3_BGE, F3_BGEU: begin
          res_valid = 1'b1;
          taken     = alu_zero;
        end
        F3_BNE, F3_BLT, F3_BLTU: begin
          res_valid = 1'b1;
          taken     = ~alu_zero;
        end
        default: ;
      endcase
    end
  end

  assign branch_taken           = taken;
  assign branch_target_actual   = !res_valid ? '0 :
                                  taken      ? ex_pc + ex_imm : ex_pc + XLEN'(4);
  assign branch_prediction_miss = res_valid & (ex_estimation != taken);
  assign update_en              = res_valid & ~ex_stall;

  // History is committed only at resolution, so it is never speculative.
  if (GHR_WIDTH == 0) begin : g_bimodal
    assign ghr_ext = '0;
  end else begin : g_gshare
    logic [GHR_WIDTH-1:0] ghr;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        ghr <= '0;
      else if (update_en)
        ghr <= GHR_WIDTH'({ghr, taken});
    end
    assign ghr_ext = IDX_W'(ghr);
  end

  for (genvar i = 0; i < PHT_ENTRIES; i++) begin : g_pht
    branch_predictor_sat_counter u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .update  (update_en && (ex_index == IDX_W'(i))),
      .taken   (taken),
      .count   (pht[i])
    );
  end

  // Fetch reads the registered entry, so a same-cycle update is not bypassed.
  assign if_index                = if_pc[IDX_W+1:2] ^ ghr_ext;
  assign branch_estimation       = if_branch & pht[if_index][PHT_CNT_W-1];
  assign branch_target_predicted = branch_estimation ? if_pc + if_imm : if_pc + XLEN'(4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count <= '0;
      miss_count   <= '0;
    end else if (update_en) begin
      if (branch_count != '1)
        branch_count <= branch_count + CNT_WIDTH'(1);
      if (branch_prediction_miss && miss_count != '1)
        miss_count <= miss_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed steps push hand-computed
// expectations; a negedge monitor pops and compares them against the outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_branch;
  logic [31:0] if_pc, if_imm;
  logic        branch_estimation;
  logic [31:0] branch_target_predicted;
  logic        branch, ex_stall;
  logic [2:0]  funct3;
  logic        alu_zero;
  logic [31:0] ex_pc, ex_imm;
  logic        ex_estimation;
  logic [5:0]  ex_index, if_index;
  logic        branch_taken;
  logic [31:0] branch_target_actual;
  logic        branch_prediction_miss;
  logic [31:0] branch_count, miss_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic        est;
    logic [31:0] tgt;
    logic [5:0]  idx;
    logic        tk;
    logic [31:0] act;
    logic        miss;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];

  branch_predictor dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .if_branch               (if_branch),
    .if_pc                   (if_pc),
    .if_imm                  (if_imm),
    .branch_estimation       (branch_estimation),
    .branch_target_predicted (branch_target_predicted),
    .branch                  (branch),
    .ex_stall                (ex_stall),
    .funct3                  (funct3),
    .alu_zero                (alu_zero),
    .ex_pc                   (ex_pc),
    .ex_imm                  (ex_imm),
    .ex_estimation           (ex_estimation),
    .ex_index                (ex_index),
    .if_index                (if_index),
    .branch_taken            (branch_taken),
    .branch_target_actual    (branch_target_actual),
    .branch_prediction_miss  (branch_prediction_miss),
    .branch_count            (branch_count),
    .miss_count              (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Monitor: outputs are combinational or registered, so they are valid
  // every negedge; compare all pending expectations there.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".estimation"}, 32'(branch_estimation),      32'(e.est));
      check({e.name, ".target_pred"}, branch_target_predicted,    e.tgt);
      check({e.name, ".if_index"},    32'(if_index),              32'(e.idx));
      check({e.name, ".taken"},       32'(branch_taken),          32'(e.tk));
      check({e.name, ".target_act"},  branch_target_actual,       e.act);
      check({e.name, ".miss"},        32'(branch_prediction_miss), 32'(e.miss));
      check({e.name, ".branch_count"}, branch_count,              e.bc);
      check({e.name, ".miss_count"},  miss_count,                 e.mc);
    end
  end

  task automatic drive(input logic ib, input logic [31:0] ipc, input logic [31:0] iimm,
                       input logic br, input logic st, input logic [2:0] f3, input logic az,
                       input logic [31:0] epc, input logic [31:0] eimm,
                       input logic eest, input logic [5:0] eidx);
    if_branch = ib;  if_pc = ipc;  if_imm = iimm;
    branch = br;     ex_stall = st; funct3 = f3;   alu_zero = az;
    ex_pc = epc;     ex_imm = eimm; ex_estimation = eest; ex_index = eidx;
  endtask

  task automatic expect_out(input string name, input logic est, input logic [31:0] tgt,
                            input logic [5:0] idx, input logic tk, input logic [31:0] act,
                            input logic miss, input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.name = name; e.est = est; e.tgt = tgt; e.idx = idx; e.tk = tk;
    e.act = act;   e.miss = miss; e.bc = bc; e.mc = mc;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after the edge that commits the previous step.
  task automatic step(input string name,
                      input logic ib, input logic [31:0] ipc, input logic [31:0] iimm,
                      input logic br, input logic st, input logic [2:0] f3, input logic az,
                      input logic [31:0] epc, input logic [31:0] eimm,
                      input logic eest, input logic [5:0] eidx,
                      input logic x_est, input logic [31:0] x_tgt, input logic [5:0] x_idx,
                      input logic x_tk, input logic [31:0] x_act, input logic x_miss,
                      input logic [31:0] x_bc, input logic [31:0] x_mc);
    @(posedge clk);
    #1;
    drive(ib, ipc, iimm, br, st, f3, az, epc, eimm, eest, eidx);
    expect_out(name, x_est, x_tgt, x_idx, x_tk, x_act, x_miss, x_bc, x_mc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Held in reset: prediction must be not-taken.
    reset_n = 1'b0;
    drive(1, 32'h100, 32'h20, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    expect_out("in_reset", 0, 32'h104, 0, 0, 0, 0, 0, 0);
    #12 reset_n = 1'b1;

    step("reset_state", 1, 32'h100, 32'h20, 0, 0, 3'b000, 0, 0, 0, 0, 0,
         0, 32'h104, 0, 0, 0, 0, 0, 0);
    // Same-cycle read and update of entry 0: read sees pre-update value.
    step("train1", 1, 32'h100, 32'h20, 1, 0, 3'b000, 1, 32'h100, 32'h20, 0, 0,
         0, 32'h104, 0, 1, 32'h120, 1, 0, 0);
    step("train2", 1, 32'h100, 32'h20, 1, 0, 3'b000, 1, 32'h100, 32'h20, 1, 0,
         0, 32'h104, 1, 1, 32'h120, 0, 1, 1);
    // GHR=3, pc[7:2]=3 -> index 0, which is now strongly taken.
    step("predict_taken", 1, 32'h10C, 32'h14, 0, 0, 3'b000, 0, 0, 0, 0, 0,
         1, 32'h120, 0, 0, 0, 0, 2, 1);
    step("not_a_branch", 0, 32'h10C, 32'h14, 0, 0, 3'b000, 0, 0, 0, 0, 0,
         0, 32'h110, 0, 0, 0, 0, 2, 1);

    for (int k = 0; k < 5; k++)
      step($sformatf("sat_hi%0d", k), 0, 32'h100, 32'h20, 1, 0, 3'b000, 1, 32'h100, 32'h20, 1, 0,
           0, 32'h104, 6'((4 << k) - 1), 1, 32'h120, 0, 32'(2 + k), 1);
    step("untrain", 0, 32'h100, 32'h20, 1, 0, 3'b000, 0, 32'h100, 32'h20, 1, 0,
         0, 32'h104, 63, 0, 32'h104, 1, 7, 1);
    // Entry 0 went 3 -> 2, still predicts taken (GHR=62, pc[7:2]=62).
    step("sat_hi_check", 1, 32'h1F8, 32'h20, 0, 0, 3'b000, 0, 0, 0, 0, 0,
         1, 32'h218, 0, 0, 0, 0, 8, 2);

    for (int k = 0; k < 5; k++)
      step($sformatf("sat_lo%0d", k), 0, 32'h100, 32'h20, 1, 0, 3'b001, 1, 32'h100, 32'h20, 0, 0,
           0, 32'h104, 6'(64 - (2 << k)), 0, 32'h104, 0, 32'(8 + k), 2);
    step("retrain_bge", 0, 32'h100, 32'h20, 1, 0, 3'b101, 1, 32'h200, 32'hFFFF_FFF0, 0, 0,
         0, 32'h104, 0, 1, 32'h1F0, 1, 13, 2);
    // Entry 0 went 0 -> 1, still predicts not-taken (GHR=1, pc[7:2]=1).
    step("sat_lo_check", 1, 32'h104, 32'h20, 0, 0, 3'b000, 0, 0, 0, 0, 0,
         0, 32'h108, 0, 0, 0, 0, 14, 3);

    step("miss_bne", 0, 32'h100, 32'h20, 1, 0, 3'b001, 1, 32'h300, 32'h40, 1, 5,
         0, 32'h104, 1, 0, 32'h304, 1, 14, 3);
    step("funct3_010", 0, 32'h100, 32'h20, 1, 0, 3'b010, 1, 32'h100, 32'h20, 1, 0,
         0, 32'h104, 2, 0, 0, 0, 15, 4);
    step("funct3_011", 0, 32'h100, 32'h20, 1, 0, 3'b011, 0, 32'h100, 32'h20, 1, 0,
         0, 32'h104, 2, 0, 0, 0, 15, 4);
    step("stall", 0, 32'h100, 32'h20, 1, 1, 3'b000, 1, 32'h100, 32'h20, 0, 0,
         0, 32'h104, 2, 1, 32'h120, 1, 15, 4);
    step("after_stall", 1, 32'h108, 32'h20, 0, 0, 3'b000, 0, 0, 0, 0, 0,
         0, 32'h10C, 0, 0, 0, 0, 15, 4);
    step("wrap", 1, 32'hFFFF_FFFC, 32'h20, 1, 0, 3'b000, 1, 32'hFFFF_FFFC, 32'h8, 0, 0,
         0, 32'h0, 61, 1, 32'h4, 1, 15, 4);
    step("pre_reset", 1, 32'h114, 32'h20, 0, 0, 3'b000, 0, 0, 0, 0, 0,
         1, 32'h134, 0, 0, 0, 0, 16, 5);

    // Reset pulsed between edges must clear GHR, PHT and counters at once.
    @(posedge clk);
    #1;
    drive(1, 32'h114, 32'h20, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    expect_out("async_reset", 0, 32'h118, 5, 0, 0, 0, 0, 0);

    step("post_reset_train", 1, 32'h100, 32'h20, 1, 0, 3'b000, 1, 32'h100, 32'h20, 0, 0,
         0, 32'h104, 0, 1, 32'h120, 1, 0, 0);
    step("post_reset_predict", 1, 32'h104, 32'h20, 0, 0, 3'b000, 0, 0, 0, 0, 0,
         1, 32'h124, 0, 0, 0, 0, 1, 1);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: address/immediate width.
REQ-002 The block SHALL have parameter PHT_ENTRIES, default 64: pattern-history-table depth, power of two, 4..1024.
REQ-003 The block SHALL have parameter GHR_WIDTH, default 6: global-history bits, 0..log2(PHT_ENTRIES); 0 selects bimodal indexing.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 32: statistics counter width.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising edge); reset_n input 1 (asynchronous, active-low).
REQ-006 Port: if_branch  input  1  fetched instruction is a conditional branch.
REQ-007 Port: if_pc  input  XLEN  fetch PC.
REQ-008 Port: if_imm  input  XLEN  fetched branch immediate.
REQ-009 Port: branch_estimation  output  1  predicted taken.
REQ-010 Port: branch_target_predicted  output  XLEN  predicted next PC.
REQ-011 Port: branch  input  1  EX-stage branch valid.
REQ-012 Port: ex_stall  input  1  EX held; suppresses update.
REQ-013 Port: funct3  input  3  branch type.
REQ-014 Port: alu_zero  input  1  ALU compare result.
REQ-015 Port: ex_pc  input  XLEN  branch PC.
REQ-016 Port: ex_imm  input  XLEN  branch immediate.
REQ-017 Port: ex_estimation  input  1  prediction carried down the pipe.
REQ-018 Port: ex_index  input  log2(PHT_ENTRIES)  PHT index used at fetch.
REQ-019 Port: if_index  output  log2(PHT_ENTRIES)  index used for this fetch.
REQ-020 Port: branch_taken  output  1  resolved outcome.
REQ-021 Port: branch_target_actual  output  XLEN  resolved next PC.
REQ-022 Port: branch_prediction_miss  output  1  redirect request.
REQ-023 Port: branch_count  output  CNT_WIDTH  resolved branches.
REQ-024 Port: miss_count  output  CNT_WIDTH  mispredictions.

Function
REQ-025 if_index SHALL be if_pc[log2(PHT_ENTRIES)+1:2] XOR zero-extended GHR.
REQ-026 Prediction SHALL be combinational: branch_estimation = if_branch AND PHT[if_index] MSB.
REQ-027 branch_target_predicted SHALL be if_pc+if_imm when branch_estimation=1, else if_pc+4, modulo 2^XLEN.
REQ-028 Resolution SHALL be combinational and SHALL apply only when branch=1 and funct3 is valid.
REQ-029 Taken decode: 000 alu_zero; 001 ~alu_zero; 100 ~alu_zero; 101 alu_zero; 110 ~alu_zero; 111 alu_zero.
REQ-030 For funct3 010/011, or branch=0, branch_taken, branch_target_actual and branch_prediction_miss SHALL be 0.
REQ-031 branch_target_actual SHALL be ex_pc+ex_imm if taken, else ex_pc+4, modulo 2^XLEN.
REQ-032 branch_prediction_miss SHALL be (ex_estimation != branch_taken) during a valid resolution.
REQ-033 Update SHALL occur at the clk edge when a valid resolution is present and ex_stall=0 (the update condition).
REQ-034 On update, PHT[ex_index] SHALL step +1 if taken, -1 if not, saturating at 3 and 0.
REQ-035 On update, GHR SHALL shift left with branch_taken entering the LSB (non-speculative history).
REQ-036 On update, branch_count SHALL increment; miss_count SHALL increment when branch_prediction_miss=1.
REQ-037 Both counters SHALL saturate at all-ones and never wrap.
REQ-038 On a same-cycle read and update of one index, the read SHALL return the pre-update value (no bypass).
REQ-039 ex_stall=1 SHALL leave the resolution outputs valid and SHALL block every state change.

Reset
REQ-040 reset_n low SHALL immediately set all PHT entries to 2'b01, GHR to 0, and both counters to 0, independent of clk.
REQ-041 Combinational outputs SHALL follow from this reset state (branch_estimation=0 while in reset).
REQ-042 A reset asserted mid-update SHALL win; no partial update SHALL persist.

Structure
REQ-043 funct3 encodings and counter state constants SHALL live in shared header modules/headers/branch.vh.
REQ-044 Per-entry saturation logic SHALL be one sub-module, SatCounter (width 2).
REQ-045 The top level SHALL hold PHT storage, GHR, statistics and the resolution decode.

Verification
REQ-046 Reset check: after reset, if_branch=1, if_pc=0x100, if_imm=0x20 -> estimation=0, target 0x104.
REQ-047 Training: BEQ alu_zero=1 at pc 0x100, resolved twice -> entry reaches 3; next fetch predicts 0x120.
REQ-048 Saturation: 5 taken updates leave the entry at 3; 5 not-taken updates leave it at 0.
REQ-049 Miss path: ex_estimation=1, BNE alu_zero=1 -> miss=1, target ex_pc+4, miss_count+1.
REQ-050 Stall and invalid types: ex_stall=1 or funct3=010 -> PHT, GHR and counters unchanged; funct3=010 outputs 0.
REQ-051 Async reset mid-run: reset_n pulsed between edges -> all state cleared before the next clk edge.
